pwm_deadtime: RTL and testbench

Converts each PWM channel output into a complementary high-side/low-side drive pair with programmable dead time, for bridge and half-bridge loads. It sits directly downstream of `pwm_core` in the core clock domain: each `pwm_o` bit feeds one pair here. A per-pair state machine guarantees that the two outputs are never high at the same time. Both-low intervals are enforced on every transition.

---
 rtl/pwm_dt_pkg.sv | 20 ++
 rtl/pwm_dt_pair.sv | 113 +++++++++++
 rtl/pwm_deadtime.sv | 82 ++++++++
 tb/tb_pwm_deadtime.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dt_pkg.sv
// pwm_dt_pkg
// Shared types and defaults for the complementary dead-time generator.
//   dt_state_e    : per-pair FSM state, OFF encoded as 0 so a cleared
//                   register always means "not driving".
//   DeadDwDefault : default width of the dead-time counters.
//   NPairsDefault : default number of complementary pairs.
package pwm_dt_pkg;

  localparam int DeadDwDefault = 8;
  localparam int NPairsDefault = 6;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    DT_HS = 3'd1,
    HS_ON = 3'd2,
    DT_LS = 3'd3,
    LS_ON = 3'd4
  } dt_state_e;

endpackage

// File: rtl/pwm_dt_pair.sv
// pwm_dt_pair
// One complementary high-side/low-side pair with dead-time insertion.
// Ports:
//   clk_core_i  : core clock
//   rst_core_ni : asynchronous active-low reset
//   pwm_i       : raw PWM bit for this pair
//   en_i        : pair enable
//   kill_i      : forces the pair to OFF (fault), same priority as en_i=0
//   dt_rise_i   : dead cycles before high side asserts, minus 1
//   dt_fall_i   : dead cycles before low side asserts, minus 1
//   hs_o        : high-side drive, registered
//   ls_o        : low-side drive, registered
//   active_o    : pair not in OFF, registered
module pwm_dt_pair
  import pwm_dt_pkg::*;
#(
  parameter int DeadDw = DeadDwDefault
) (
  input  logic              clk_core_i,
  input  logic              rst_core_ni,
  input  logic              pwm_i,
  input  logic              en_i,
  input  logic              kill_i,
  input  logic [DeadDw-1:0] dt_rise_i,
  input  logic [DeadDw-1:0] dt_fall_i,
  output logic              hs_o,
  output logic              ls_o,
  output logic              active_o
);

  dt_state_e         state_q, state_d;
  logic [DeadDw-1:0] cnt_q, cnt_d;

  // Next-state logic. Every route into an ON state passes through a DT_*
  // state whose counter is freshly loaded, which is what guarantees the
  // both-low gap. An abort from one DT state to the other reloads the
  // counter, so a short pwm pulse never shortens the opposite gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en_i || kill_i) begin
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          if (pwm_i) begin
            state_d = DT_HS;
            cnt_d   = dt_rise_i;
          end else begin
            state_d = DT_LS;
            cnt_d   = dt_fall_i;
          end
        end
        DT_HS: begin
          if (!pwm_i) begin
            state_d = DT_LS;
            cnt_d   = dt_fall_i;
          end else if (cnt_q == '0) begin
            state_d = HS_ON;
          end else begin
            cnt_d = cnt_q - DeadDw'(1);
          end
        end
        DT_LS: begin
          if (pwm_i) begin
            state_d = DT_HS;
            cnt_d   = dt_rise_i;
          end else if (cnt_q == '0) begin
            state_d = LS_ON;
          end else begin
            cnt_d = cnt_q - DeadDw'(1);
          end
        end
        HS_ON: begin
          if (!pwm_i) begin
            state_d = DT_LS;
            cnt_d   = dt_fall_i;
          end
        end
        LS_ON: begin
          if (pwm_i) begin
            state_d = DT_HS;
            cnt_d   = dt_rise_i;
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state register, with no combinational path to the pins.
  always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
    if (!rst_core_ni) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      hs_o     <= 1'b0;
      ls_o     <= 1'b0;
      active_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hs_o     <= (state_d == HS_ON);
      ls_o     <= (state_d == LS_ON);
      active_o <= (state_d != OFF);
    end
  end

endmodule

// File: rtl/pwm_deadtime.sv
// pwm_deadtime
// Turns each pwm_core output bit into a complementary high/low-side drive
// pair with programmable dead time; both sides are never high together.
// Ports:
//   clk_core_i  : core clock
//   rst_core_ni : asynchronous active-low reset
//   pwm_i       : raw PWM, one bit per pair
//   en_i        : per-pair enable
//   dt_rise_i   : dead cycles before high side asserts, minus 1
//   dt_fall_i   : dead cycles before low side asserts, minus 1
//   hs_o        : high-side drives, registered
//   ls_o        : low-side drives, registered
//   active_o    : pair not in OFF
//   fault_i     : sets the sticky fault latch      (PWM_DT_FAULT_EN only)
//   fault_clr_i : clears the fault latch           (PWM_DT_FAULT_EN only)
//   fault_o     : fault latch state                (PWM_DT_FAULT_EN only)
// Build option: define PWM_DT_FAULT_EN to add the fault latch and ports.
module pwm_deadtime
  import pwm_dt_pkg::*;
#(
  parameter int NPairs = NPairsDefault,
  parameter int DeadDw = DeadDwDefault
) (
  input  logic              clk_core_i,
  input  logic              rst_core_ni,
  input  logic [NPairs-1:0] pwm_i,
  input  logic [NPairs-1:0] en_i,
  input  logic [DeadDw-1:0] dt_rise_i,
  input  logic [DeadDw-1:0] dt_fall_i,
  output logic [NPairs-1:0] hs_o,
  output logic [NPairs-1:0] ls_o,
  output logic [NPairs-1:0] active_o
`ifdef PWM_DT_FAULT_EN
  ,
  input  logic              fault_i,
  input  logic              fault_clr_i,
  output logic              fault_o
`endif
);

  logic kill;

`ifdef PWM_DT_FAULT_EN
  logic fault_q;

  // Sticky fault latch; a new fault beats a clear in the same cycle.
  always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
    if (!rst_core_ni) begin
      fault_q <= 1'b0;
    end else if (fault_i) begin
      fault_q <= 1'b1;
    end else if (fault_clr_i) begin
      fault_q <= 1'b0;
    end
  end

  // fault_i is included directly so the pairs drop on the same edge that
  // sets the latch, and the latch keeps them in OFF until it is cleared.
  assign kill    = fault_i | fault_q;
  assign fault_o = fault_q;
`else
  assign kill = 1'b0;
`endif

  for (genvar i = 0; i < NPairs; i++) begin : g_pair
    pwm_dt_pair #(
      .DeadDw(DeadDw)
    ) u_pair (
      .clk_core_i (clk_core_i),
      .rst_core_ni(rst_core_ni),
      .pwm_i      (pwm_i[i]),
      .en_i       (en_i[i]),
      .kill_i     (kill),
      .dt_rise_i  (dt_rise_i),
      .dt_fall_i  (dt_fall_i),
      .hs_o       (hs_o[i]),
      .ls_o       (ls_o[i]),
      .active_o   (active_o[i])
    );
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime
// Self-checking bench for pwm_deadtime. Pairs 0..NP-2 are driven together,
// the top pair is held disabled and must stay quiet. Expected outputs are
// derived from the dead-time timing rules and queued per cycle.
// Define PWM_DT_FAULT_EN to also exercise the fault latch.
module tb_pwm_deadtime;

  localparam int NP = 6;
  localparam int DW = 8;
  localparam logic [NP-1:0] Mask = {1'b0, {(NP-1){1'b1}}};

  logic          clk_core;
  logic          rst_core_n;
  logic [NP-1:0] pwm;
  logic [NP-1:0] en;
  logic [DW-1:0] dt_rise;
  logic [DW-1:0] dt_fall;
  logic [NP-1:0] hs;
  logic [NP-1:0] ls;
  logic [NP-1:0] active;
`ifdef PWM_DT_FAULT_EN
  logic          fault;
  logic          fault_clr;
  logic          fault_out;
`endif

  typedef struct {
    string         tag;
    logic [NP-1:0] hs;
    logic [NP-1:0] ls;
    logic [NP-1:0] act;
  } sb_item_t;

  sb_item_t sb[$];
  int total_checks = 0;
  int bad_checks   = 0;

  pwm_deadtime #(
    .NPairs(NP),
    .DeadDw(DW)
  ) dut (
    .clk_core_i (clk_core),
    .rst_core_ni(rst_core_n),
    .pwm_i      (pwm),
    .en_i       (en),
    .dt_rise_i  (dt_rise),
    .dt_fall_i  (dt_fall),
    .hs_o       (hs),
    .ls_o       (ls),
    .active_o   (active)
`ifdef PWM_DT_FAULT_EN
    ,
    .fault_i    (fault),
    .fault_clr_i(fault_clr),
    .fault_o    (fault_out)
`endif
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle at the negedge and queue what the outputs must be
  // after the following posedge; returns 1 time unit after that posedge.
  task automatic applyStimulus(input logic p, input logic e, input logic eh,
                               input logic el, input logic ea, input string tag);
    sb_item_t item;
    @(negedge clk_core);
    pwm = {NP{p}};
    en  = e ? Mask : '0;
    item.tag = tag;
    item.hs  = eh ? Mask : '0;
    item.ls  = el ? Mask : '0;
    item.act = ea ? Mask : '0;
    sb.push_back(item);
    @(posedge clk_core);
    #1;
  endtask

  // Side change to pwm level p with loaded dead value dt: dt+1 both-low
  // cycles, then the side selected by p for hold cycles.
  task automatic runPhase(input string tag, input logic p, input int dt, input int hold);
    for (int i = 0; i <= dt; i++) applyStimulus(p, 1'b1, 1'b0, 1'b0, 1'b1, {tag, "_dead"});
    for (int i = 0; i < hold; i++) applyStimulus(p, 1'b1, p, !p, 1'b1, {tag, "_drive"});
  endtask

  // Scoreboard consumer: compares the queued expectation for each edge.
  always @(posedge clk_core) begin
    sb_item_t item;
    #1;
    if (sb.size() > 0) begin
      item = sb.pop_front();
      checkOutput({item.tag, "_hs"},  32'(hs),     32'(item.hs));
      checkOutput({item.tag, "_ls"},  32'(ls),     32'(item.ls));
      checkOutput({item.tag, "_act"}, 32'(active), 32'(item.act));
    end
  end

  // Shoot-through guard on every cycle, reset included.
  always @(negedge clk_core) begin
    checkOutput("no_overlap", 32'(hs & ls), 32'd0);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_core_n = 1'b0;
    pwm        = '0;
    en         = '0;
    dt_rise    = '0;
    dt_fall    = '0;
`ifdef PWM_DT_FAULT_EN
    fault      = 1'b0;
    fault_clr  = 1'b0;
`endif
    #12;
    checkOutput("rst_hs",  32'(hs),     32'd0);
    checkOutput("rst_ls",  32'(ls),     32'd0);
    checkOutput("rst_act", 32'(active), 32'd0);
`ifdef PWM_DT_FAULT_EN
    checkOutput("rst_fault", 32'(fault_out), 32'd0);
`endif
    @(negedge clk_core);
    rst_core_n = 1'b1;
    @(posedge clk_core);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Basic transitions with 4-cycle gaps.
    dt_rise = 8'd3;
    dt_fall = 8'd3;
    runPhase("en_ls", 1'b0, 3, 6);
    runPhase("rise3", 1'b1, 3, 6);
    runPhase("fall3", 1'b0, 3, 4);

    // Zero dead time: single-cycle gaps on a period-20 square wave.
    dt_rise = 8'd0;
    dt_fall = 8'd0;
    for (int i = 0; i < 3; i++) begin
      runPhase("sq_hi", 1'b1, 0, 9);
      runPhase("sq_lo", 1'b0, 0, 9);
    end

    // 3-cycle pulse shorter than the rising gap is swallowed.
    dt_rise = 8'd5;
    dt_fall = 8'd5;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "pulse");
    runPhase("pulse_end", 1'b0, 5, 3);

    // dt_rise change mid-countdown only affects the next load.
    dt_rise = 8'd7;
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "dtchg_dead");
    dt_rise = 8'd1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "dtchg_dead");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "dtchg_drive");
    dt_fall = 8'd2;
    runPhase("dtchg_fall", 1'b0, 2, 3);
    runPhase("dtchg_rise", 1'b1, 1, 3);

    // Enable dropped in the middle of a dead interval.
    dt_fall = 8'd4;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "endrop_dt");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "endrop_dt");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "endrop_off");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "endrop_off");
    dt_rise = 8'd2;
    runPhase("reen", 1'b1, 2, 4);

    // Asynchronous reset while the high side is driven.
    #3;
    rst_core_n = 1'b0;
    #1;
    checkOutput("arst_hs",  32'(hs),     32'd0);
    checkOutput("arst_ls",  32'(ls),     32'd0);
    checkOutput("arst_act", 32'(active), 32'd0);
    en = '0;
    @(negedge clk_core);
    rst_core_n = 1'b1;
    @(posedge clk_core);
    #1;
    dt_rise = 8'd1;
    runPhase("post_rst", 1'b1, 1, 3);

`ifdef PWM_DT_FAULT_EN
    // Fault during HS_ON: immediate OFF, sticky, fault beats clear.
    fault = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "fault_hit");
    fault = 1'b0;
    checkOutput("fault_set", 32'(fault_out), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "fault_hold");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "fault_hold");
    checkOutput("fault_held", 32'(fault_out), 32'd1);
    fault     = 1'b1;
    fault_clr = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "fault_both");
    checkOutput("fault_wins", 32'(fault_out), 32'd1);
    fault = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "fault_clr_edge");
    fault_clr = 1'b0;
    checkOutput("fault_cleared", 32'(fault_out), 32'd0);
    dt_rise = 8'd3;
    runPhase("fault_resume", 1'b1, 3, 3);
`endif

    @(negedge clk_core);
    @(negedge clk_core);
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
